// File: rtl/port_io_ctrl.sv
// Host pad bridge: 64-word inbound/outbound FIFOs behind an RX/TX turnaround FSM.
// Inbound words fall through to IF_rd_* one cycle after the strobe; outbound pops are registered onto O_spi_data.
module port_io_ctrl #(
  parameter int PORT_WIDTH      = 128,
  parameter int FIFO_ADDR_WIDTH = 6,
  parameter int NEAR_GAP        = 4,
  parameter int TX_BURST        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  I_spi_cs_n,
  input  logic [PORT_WIDTH-1:0] I_spi_data,
  output logic [PORT_WIDTH-1:0] O_spi_data,
  output logic                  O_tx_val,
  output logic                  O_switch_rdwr,
  output logic                  O_near_full,
  output logic                  O_config_req,
  output logic                  O_rx_ovf,
  input  logic                  CCU_cfg_req,
  output logic                  IF_rd_val,
  input  logic                  IF_rd_rdy,
  output logic [PORT_WIDTH-1:0] IF_rd_data,
  input  logic                  OF_wr_val,
  output logic                  OF_wr_rdy,
  input  logic [PORT_WIDTH-1:0] OF_wr_data
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int CW    = FIFO_ADDR_WIDTH + 1;
  localparam int BW    = $clog2(TX_BURST + 1);

  localparam logic [CW-1:0]              DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]              NEAR_C    = CW'(DEPTH - NEAR_GAP);
  localparam logic [CW-1:0]              CNT_ONE   = CW'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE   = FIFO_ADDR_WIDTH'(1);
  localparam logic [BW-1:0]              BURST_C   = BW'(TX_BURST);
  localparam logic [BW-1:0]              BURST_ONE = BW'(1);

  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_t;
  state_t state, state_nxt;

  logic [PORT_WIDTH-1:0]      in_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] in_wr_ptr, in_rd_ptr;
  logic [CW-1:0]              in_cnt, in_cnt_nxt;
  logic                       in_strobe, in_full, in_push, in_pop;

  logic [PORT_WIDTH-1:0]      out_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] out_wr_ptr, out_rd_ptr;
  logic [CW-1:0]              out_cnt, out_cnt_nxt;
  logic                       out_push, out_pop;
  logic [BW-1:0]              burst_cnt;

  // A full FIFO still accepts a strobe when the core pops in the same cycle.
  assign in_strobe  = (state == RX) && !I_spi_cs_n;
  assign in_full    = (in_cnt == DEPTH_C);
  assign IF_rd_val  = (in_cnt != '0);
  assign in_pop     = IF_rd_val && IF_rd_rdy;
  assign in_push    = in_strobe && (!in_full || in_pop);
  assign IF_rd_data = IF_rd_val ? in_mem[in_rd_ptr] : '0;

  assign OF_wr_rdy  = (out_cnt != DEPTH_C);
  assign out_push   = OF_wr_val && OF_wr_rdy;
  assign out_pop    = (state == TX) && (out_cnt != '0);

  always_comb begin
    in_cnt_nxt = in_cnt;
    if (in_push && !in_pop)      in_cnt_nxt = in_cnt + CNT_ONE;
    else if (!in_push && in_pop) in_cnt_nxt = in_cnt - CNT_ONE;
  end

  always_comb begin
    out_cnt_nxt = out_cnt;
    if (out_push && !out_pop)      out_cnt_nxt = out_cnt + CNT_ONE;
    else if (!out_push && out_pop) out_cnt_nxt = out_cnt - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX:      if (out_cnt != '0 && I_spi_cs_n) state_nxt = TURN_TX;
      TURN_TX: state_nxt = TX;
      TX: begin
        // A push racing the last pop keeps the count up and extends the burst.
        if (!out_pop || out_cnt_nxt == '0 || (burst_cnt + BURST_ONE) == BURST_C)
          state_nxt = TURN_RX;
      end
      TURN_RX: state_nxt = RX;
      default: state_nxt = RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr]   <= I_spi_data;
    if (out_push) out_mem[out_wr_ptr] <= OF_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wr_ptr     <= '0;
      in_rd_ptr     <= '0;
      in_cnt        <= '0;
      out_wr_ptr    <= '0;
      out_rd_ptr    <= '0;
      out_cnt       <= '0;
      burst_cnt     <= '0;
      O_spi_data    <= '0;
      O_tx_val      <= 1'b0;
      O_switch_rdwr <= 1'b0;
      O_near_full   <= 1'b0;
      O_config_req  <= 1'b0;
      O_rx_ovf      <= 1'b0;
    end else begin
      if (in_push)  in_wr_ptr  <= in_wr_ptr + PTR_ONE;
      if (in_pop)   in_rd_ptr  <= in_rd_ptr + PTR_ONE;
      if (out_push) out_wr_ptr <= out_wr_ptr + PTR_ONE;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + PTR_ONE;
      in_cnt  <= in_cnt_nxt;
      out_cnt <= out_cnt_nxt;

      if (state == TURN_TX) burst_cnt <= '0;
      else if (out_pop)     burst_cnt <= burst_cnt + BURST_ONE;

      O_tx_val <= out_pop;
      if (out_pop) O_spi_data <= out_mem[out_rd_ptr];

      O_switch_rdwr <= (state_nxt == TURN_TX) || (state_nxt == TX);
      O_near_full   <= (in_cnt_nxt >= NEAR_C);

      if (CCU_cfg_req)  O_config_req <= 1'b1;
      else if (in_push) O_config_req <= 1'b0;

      if (in_strobe && !in_push) O_rx_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/port_io_ctrl.md
PORT_IO_CTRL -- requirements
Module: port_io_ctrl

Interface
REQ-001 The block SHALL have parameter PORT_WIDTH, default 128, the pad data bus width in bits.
REQ-002 The block SHALL have parameter FIFO_ADDR_WIDTH, default 6; each FIFO depth is DEPTH = 2^FIFO_ADDR_WIDTH = 64 words.
REQ-003 The block SHALL have parameter NEAR_GAP, default 4, the free-slot threshold for near-full.
REQ-004 The block SHALL have parameter TX_BURST, default 16, the maximum number of words per transmit burst.
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; clk and rst_n SHALL be the first ports.
REQ-006 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- I_spi_cs_n  in  1  host word strobe, active-low.
- I_spi_data  in  PORT_WIDTH  host-to-chip word.
- O_spi_data  out  PORT_WIDTH  chip-to-host word, registered.
- O_tx_val  out  1  O_spi_data valid this cycle.
- O_switch_rdwr  out  1  bus direction: 0 = host drives, 1 = chip drives.
- O_near_full  out  1  inbound FIFO has at most NEAR_GAP free slots.
- O_config_req  out  1  chip requests configuration from host.
- O_rx_ovf  out  1  sticky inbound overflow flag.
- CCU_cfg_req  in  1  core pulse that raises O_config_req.
- IF_rd_val  out  1  inbound FIFO non-empty.
- IF_rd_rdy  in  1  core pops the inbound word.
- IF_rd_data  out  PORT_WIDTH  inbound FIFO head, first-word fall-through.
- OF_wr_val  in  1  core pushes an outbound word.
- OF_wr_rdy  out  1  outbound FIFO not full.
- OF_wr_data  in  PORT_WIDTH  outbound word.

Function
REQ-007 The FSM SHALL have four states: RX, TURN_TX, TX, TURN_RX; it SHALL start in RX.
REQ-008 O_switch_rdwr SHALL be registered: 0 in RX and TURN_RX, 1 in TURN_TX and TX.
REQ-009 In RX, when I_spi_cs_n=0 and inbound count < DEPTH, the block SHALL write I_spi_data to the inbound FIFO at that clock edge.
REQ-010 The written word SHALL be visible on IF_rd_val/IF_rd_data in the next cycle.
REQ-011 In RX, when I_spi_cs_n=0 and the inbound FIFO is full, the word SHALL be dropped, O_rx_ovf SHALL be set, and O_rx_ovf SHALL stay set until reset.
REQ-012 In TURN_TX, TX and TURN_RX, I_spi_cs_n and I_spi_data SHALL be ignored: no write to the inbound FIFO and no overflow.
REQ-013 The inbound FIFO SHALL pop when IF_rd_val=1 and IF_rd_rdy=1.
REQ-014 A simultaneous push and pop SHALL leave the inbound count unchanged, including when the FIFO is full (pop frees the slot in the same cycle).
REQ-015 O_near_full SHALL be registered, computed from next-state count: 1 iff count >= DEPTH-NEAR_GAP (>= 60 by default).
REQ-016 The outbound FIFO SHALL push when OF_wr_val=1 and OF_wr_rdy=1; OF_wr_rdy SHALL equal (outbound count < DEPTH).
REQ-017 RX SHALL move to TURN_TX when the outbound count is > 0 and I_spi_cs_n=1 in the same cycle; otherwise it SHALL stay in RX.
REQ-018 TURN_TX SHALL last exactly one cycle and SHALL then go to TX; O_tx_val SHALL be 0 during it.
REQ-019 In TX, the block SHALL pop one outbound word per cycle into O_spi_data with O_tx_val=1 on the following cycle, and SHALL increment a burst counter.
REQ-020 TX SHALL go to TURN_RX after the pop that empties the outbound FIFO or the TX_BURST-th pop, whichever comes first.
REQ-021 The burst counter SHALL clear on entry to TX.
REQ-022 TURN_RX SHALL last one cycle with O_tx_val=0 (except the registered final word, per REQ-019) and SHALL then go to RX.
REQ-023 A core push during TX SHALL be eligible for pop in the same burst once it is in the FIFO; simultaneous push and pop SHALL keep the count.
REQ-024 O_spi_data SHALL hold its last value when O_tx_val=0.
REQ-025 CCU_cfg_req=1 SHALL set O_config_req at the next edge.
REQ-026 O_config_req SHALL clear on the first accepted inbound word in RX (REQ-009).
REQ-027 If a set and a clear occur in the same cycle, set SHALL win.

Reset
REQ-028 When rst_n=0 the block SHALL, asynchronously: enter RX; empty both FIFOs; clear the burst counter.
REQ-029 During reset all outputs SHALL be 0: O_spi_data, O_tx_val, O_switch_rdwr, O_near_full, O_config_req, O_rx_ovf, IF_rd_val, IF_rd_data; OF_wr_rdy SHALL be 1.
REQ-030 Reset asserted mid-burst SHALL discard all FIFO contents; after release the block SHALL resume in RX with no partial word emitted.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Fill: 64 strobed words with IF_rd_rdy=0 -> O_near_full=1 after word 60 is accepted; 65th word dropped; O_rx_ovf=1; IF_rd_data=word 0.
- Full with pop: push and pop in the same cycle while count=64 -> word accepted, count stays 64, O_rx_ovf stays 0.
- Burst: 20 outbound words, I_spi_cs_n=1 -> O_switch_rdwr=1 after 1 cycle; 16 consecutive O_tx_val pulses in order; TURN_RX; return to RX; second burst of 4 words.
- Host busy: outbound non-empty while I_spi_cs_n=0 -> stays in RX until I_spi_cs_n=1.
- Config: CCU_cfg_req pulse -> O_config_req=1; first inbound word clears it; set and clear in the same cycle -> stays 1.
- Reset: rst_n low mid-TX at word 5 -> all outputs 0 immediately; after release, RX with empty FIFOs and OF_wr_rdy=1.
